// File: rtl/replay_stream_decoder_if.sv
// Bus bundle between the replay-buffer mux, the stream decoder and the neuron stage.
interface replay_stream_decoder_if #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned TICKS      = 8
);
  localparam int unsigned TW = $clog2(TICKS + 1);

  logic                     gamma_start;
  logic                     spike_in;
  logic                     out_ready;
  logic                     out_valid;
  logic [NUM_INPUTS*TW-1:0] out_times;
  logic [NUM_INPUTS-1:0]    out_mask;
  logic                     busy;
  logic                     overflow;

  modport master (
    output gamma_start, spike_in, out_ready,
    input  out_valid, out_times, out_mask, busy, overflow
  );

  modport slave (
    input  gamma_start, spike_in, out_ready,
    output out_valid, out_times, out_mask, busy, overflow
  );
endinterface

// File: rtl/replay_stream_decoder.sv
// Demultiplexes the replay buffer's serial spike stream into per-input first-spike
// times and publishes one packed time vector per gamma cycle over valid/ready.
module replay_stream_decoder #(
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned TICKS      = 8
) (
  input  logic                    clk,
  input  logic                    grst,
  replay_stream_decoder_if.slave  bus
);
  localparam int unsigned TW = $clog2(TICKS + 1);
  localparam int unsigned PW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int unsigned KW = (TICKS > 1) ? $clog2(TICKS) : 1;

  localparam logic [TW-1:0] NO_SPIKE   = TW'(TICKS);
  localparam logic [PW-1:0] LAST_PHASE = PW'(NUM_INPUTS - 1);
  localparam logic [KW-1:0] LAST_TICK  = KW'(TICKS - 1);

  typedef enum logic {IDLE, CAPTURE} state_e;
  typedef logic [NUM_INPUTS-1:0][TW-1:0] times_t;

  state_e                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [KW-1:0]         tick_q, tick_d;
  times_t                shadow_q, shadow_d;
  logic [NUM_INPUTS-1:0] seen_q, seen_d;
  logic                  out_valid_q, out_valid_d;
  times_t                out_times_q, out_times_d;
  logic [NUM_INPUTS-1:0] out_mask_q, out_mask_d;
  logic                  busy_q, busy_d;
  logic                  overflow_q, overflow_d;
  logic                  last_sample;

  // State register
  always_ff @(posedge clk or posedge grst) begin
    if (grst) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      tick_q      <= '0;
      shadow_q    <= {NUM_INPUTS{NO_SPIKE}};
      seen_q      <= '0;
      out_valid_q <= 1'b0;
      out_times_q <= {NUM_INPUTS{NO_SPIKE}};
      out_mask_q  <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      shadow_q    <= shadow_d;
      seen_q      <= seen_d;
      out_valid_q <= out_valid_d;
      out_times_q <= out_times_d;
      out_mask_q  <= out_mask_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  // Capture sequencing, result publication and handshake
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    tick_d      = tick_q;
    shadow_d    = shadow_q;
    seen_d      = seen_q;
    out_valid_d = out_valid_q;
    out_times_d = out_times_q;
    out_mask_d  = out_mask_q;
    overflow_d  = overflow_q;
    last_sample = (state_q == CAPTURE) && (phase_q == LAST_PHASE) && (tick_q == LAST_TICK);

    if (bus.out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.gamma_start) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (bus.spike_in && !seen_q[phase_q]) begin
          shadow_d[phase_q] = TW'(tick_q);
          seen_d[phase_q]   = 1'b1;
        end
        if (tick_q == LAST_TICK) begin
          tick_d  = '0;
          phase_d = phase_q + 1'b1;
        end else begin
          tick_d = tick_q + 1'b1;
        end
        if (last_sample) begin
          // The final sample is folded in through shadow_d/seen_d
          if (!out_valid_q || bus.out_ready) begin
            out_times_d = shadow_d;
            out_mask_d  = seen_d;
            out_valid_d = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          phase_d = '0;
          tick_d  = '0;
          state_d = bus.gamma_start ? CAPTURE : IDLE;
        end else if (bus.gamma_start) begin
          overflow_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A gamma_start always opens a fresh capture window
    if (bus.gamma_start) begin
      phase_d  = '0;
      tick_d   = '0;
      shadow_d = {NUM_INPUTS{NO_SPIKE}};
      seen_d   = '0;
    end

    busy_d = (state_d == CAPTURE);
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_times = out_times_q;
  assign bus.out_mask  = out_mask_q;
  assign bus.busy      = busy_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_replay_stream_decoder.sv
// Directed plus randomized bench for replay_stream_decoder against a per-gamma-cycle
// reference model that derives first-spike times directly from the sample pattern.
module tb_replay_stream_decoder;
  localparam int unsigned NUM_INPUTS = 2;
  localparam int unsigned TICKS      = 8;
  localparam int unsigned TW         = $clog2(TICKS + 1);
  localparam int unsigned NS         = NUM_INPUTS * TICKS;

  logic clk = 1'b0;
  logic grst;
  always #5 clk = ~clk;

  replay_stream_decoder_if #(.NUM_INPUTS(NUM_INPUTS), .TICKS(TICKS)) bus ();

  replay_stream_decoder #(.NUM_INPUTS(NUM_INPUTS), .TICKS(TICKS)) dut (
    .clk  (clk),
    .grst (grst),
    .bus  (bus.slave)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic                     m_valid, m_busy, m_ovf;
  logic [NUM_INPUTS*TW-1:0] m_times;
  logic [NUM_INPUTS-1:0]    m_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},    32'(bus.out_valid), 32'(m_valid));
    chk({tag, ".times"},    32'(bus.out_times), 32'(m_times));
    chk({tag, ".mask"},     32'(bus.out_mask),  32'(m_mask));
    chk({tag, ".busy"},     32'(bus.busy),      32'(m_busy));
    chk({tag, ".overflow"}, 32'(bus.overflow),  32'(m_ovf));
  endtask

  // First spike of each phase; TICKS when the phase is silent
  task automatic expected(input logic [NS-1:0] spk,
                          output logic [NUM_INPUTS*TW-1:0] t,
                          output logic [NUM_INPUTS-1:0] m);
    for (int k = 0; k < NUM_INPUTS; k++) begin
      t[k*TW +: TW] = TW'(TICKS);
      m[k] = 1'b0;
      for (int s = TICKS - 1; s >= 0; s--) begin
        if (spk[k*TICKS + s]) begin
          t[k*TW +: TW] = TW'(s);
          m[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_ovf   = 1'b0;
    m_mask  = '0;
    for (int k = 0; k < NUM_INPUTS; k++) m_times[k*TW +: TW] = TW'(TICKS);
  endtask

  task automatic clock_edge(input bit ready, input bit complete, input logic [NS-1:0] spk,
                            input bit busy_after, input string tag);
    logic [NUM_INPUTS*TW-1:0] t;
    logic [NUM_INPUTS-1:0]    m;
    bit                       pub;
    pub = !m_valid || ready;
    bus.out_ready = ready;
    if (ready) m_valid = 1'b0;
    if (complete) begin
      if (pub) begin
        expected(spk, t, m);
        m_times = t;
        m_mask  = m;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_busy = busy_after;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic capture(input logic [NS-1:0] spk, input bit ready, input bit pulse,
                         input bit chain, input string tag);
    if (pulse) begin
      bus.gamma_start = 1'b1;
      bus.spike_in    = 1'b0;
      clock_edge(ready, 1'b0, spk, 1'b1, {tag, "_start"});
    end
    for (int i = 0; i < NS; i++) begin
      bus.gamma_start = chain && (i == NS - 1);
      bus.spike_in    = spk[i];
      clock_edge(ready, i == NS - 1, spk, (i != NS - 1) || chain, tag);
    end
    bus.gamma_start = 1'b0;
    bus.spike_in    = 1'b0;
  endtask

  task automatic partial(input logic [NS-1:0] spk, input int n, input bit ready);
    bus.gamma_start = 1'b1;
    bus.spike_in    = 1'b0;
    clock_edge(ready, 1'b0, spk, 1'b1, "part_start");
    bus.gamma_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.spike_in = spk[i];
      clock_edge(ready, 1'b0, spk, 1'b1, "part");
    end
    bus.spike_in = 1'b0;
  endtask

  task automatic idle(input bit ready);
    bus.gamma_start = 1'b0;
    bus.spike_in    = 1'($urandom_range(0, 1));
    clock_edge(ready, 1'b0, '0, 1'b0, "idle");
    bus.spike_in    = 1'b0;
  endtask

  initial begin
    logic [NS-1:0] spk;
    bit            r, ch, pend;

    bus.gamma_start = 1'b0;
    bus.spike_in    = 1'b0;
    bus.out_ready   = 1'b0;
    grst            = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    chk("reset_times_const", 32'(bus.out_times), 32'h88);
    #4 grst = 1'b0;
    @(posedge clk);
    #1;

    // Basic two-input capture with spikes at phase0 tick3 and phase1 tick5
    capture(16'h2008, 1'b1, 1'b1, 1'b0, "t1");
    chk("t1_times_const", 32'(bus.out_times), 32'h53);
    chk("t1_mask_const",  32'(bus.out_mask),  32'h3);
    chk("t1_ovf_const",   32'(bus.overflow),  32'h0);

    // First spike wins; silent input reports TICKS
    capture(16'h0085, 1'b1, 1'b1, 1'b0, "t2");
    chk("t2_times_const", 32'(bus.out_times), 32'h80);
    chk("t2_mask_const",  32'(bus.out_mask),  32'h1);

    // Spike on the very last sample is included
    capture(16'h8000, 1'b1, 1'b1, 1'b0, "t3");
    chk("t3_times_const", 32'(bus.out_times), 32'h78);
    chk("t3_mask_const",  32'(bus.out_mask),  32'h2);

    // gamma_start coincident with last sample: publish then restart, no overflow
    capture(16'h0102, 1'b1, 1'b1, 1'b1, "chain_a");
    chk("chain_a_times", 32'(bus.out_times), 32'h01);
    chk("chain_busy",    32'(bus.busy),      32'h1);
    capture(16'h0400, 1'b1, 1'b0, 1'b0, "chain_b");
    chk("chain_b_times", 32'(bus.out_times), 32'h28);
    chk("chain_ovf",     32'(bus.overflow),  32'h0);
    idle(1'b1);

    // Abort at phase1 tick2, restarted cycle publishes its own data
    partial(16'h0005, 10, 1'b1);
    m_ovf = 1'b1;
    capture(16'h2040, 1'b1, 1'b1, 1'b0, "restart");
    chk("restart_times", 32'(bus.out_times), 32'h56);
    chk("restart_ovf",   32'(bus.overflow),  32'h1);

    // Asynchronous reset in the middle of phase 0
    partial(16'h0008, 4, 1'b1);
    #2 grst = 1'b1;
    model_reset();
    #1;
    check_all("mid_reset");
    chk("mid_reset_times", 32'(bus.out_times), 32'h88);
    chk("mid_reset_busy",  32'(bus.busy),      32'h0);
    #2 grst = 1'b0;

    // Backpressure across two cycles: first held, second dropped
    capture(16'h0202, 1'b0, 1'b1, 1'b0, "bp_a");
    chk("bp_a_ovf", 32'(bus.overflow), 32'h0);
    capture(16'h0001, 1'b0, 1'b1, 1'b0, "bp_b");
    chk("bp_held_times", 32'(bus.out_times), 32'h11);
    chk("bp_held_mask",  32'(bus.out_mask),  32'h3);
    chk("bp_ovf",        32'(bus.overflow),  32'h1);
    idle(1'b1);
    chk("bp_drain_valid", 32'(bus.out_valid), 32'h0);
    chk("bp_drain_ovf",   32'(bus.overflow),  32'h1);

    // Randomized cycles, with random aborts, chaining and backpressure
    grst = 1'b1;
    model_reset();
    #2 grst = 1'b0;
    pend = 1'b0;
    for (int it = 0; it < 40; it++) begin
      spk = NS'($urandom & $urandom & $urandom);
      r   = 1'($urandom_range(0, 1));
      ch  = ($urandom_range(0, 3) == 0);
      if (!pend && $urandom_range(0, 4) == 0) begin
        partial(NS'($urandom), $urandom_range(1, NS - 1), 1'($urandom_range(0, 1)));
        m_ovf = 1'b1;
      end
      capture(spk, r, !pend, ch, "rnd");
      pend = ch;
      if (!pend) begin
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) idle(1'($urandom_range(0, 1)));
      end
    end
    if (pend) capture(NS'($urandom), 1'b1, 1'b0, 1'b0, "rnd_tail");
    idle(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
